// File: rtl/codec_adc_capture.sv
// I2S ADC capture: deserialises 16-bit codec samples into ping-pong byte buffer halves
// with a filled/ack handover. Define CAPTURE_MONO_EN to store the left channel only.
module codec_adc_capture #(
  parameter int BUFFER_ADDR_BITS = 9,
  parameter int SAMPLE_BITS      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        capture_en_i,
  input  logic                        codec_bclk_i,
  input  logic                        codec_adclrck_i,
  input  logic                        codec_adcdat_i,
  output logic [BUFFER_ADDR_BITS-1:0] capture_buffer_addr_o,
  output logic                        capture_buffer_sel_o,
  output logic [7:0]                  capture_buffer_data_o,
  output logic                        capture_buffer_wren_o,
  output logic                        capture_buffer_filled_o,
  input  logic                        capture_buffer_filled_ack_i,
  output logic                        capture_overrun_o
);

  localparam int CNT_W = $clog2(SAMPLE_BITS);
`ifdef CAPTURE_MONO_EN
  localparam bit MONO = 1'b1;
`else
  localparam bit MONO = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_FRAME, S_SKIP, S_SHIFT, S_WRITE_LO, S_WRITE_HI, S_CH_END
  } state_t;

  state_t                      r_state, w_next;
  logic [2:0]                  r_bclk_sync;
  logic [1:0]                  r_lrck_sync, r_dat_sync;
  logic                        r_lrck_prev, r_right;
  logic [CNT_W-1:0]            r_bit_cnt;
  logic [SAMPLE_BITS-1:0]      r_shift;
  logic [BUFFER_ADDR_BITS-1:0] r_ptr;
  logic                        r_sel, r_filled, r_overrun;

  logic w_bclk_rise, w_lrck, w_dat, w_lrck_edge, w_left_start, w_right_start;
  logic w_last_bit, w_half_end;

  // Stage [2] of the bclk chain only exists to edge-detect the synchronised level.
  assign w_bclk_rise   = r_bclk_sync[1] & ~r_bclk_sync[2];
  assign w_lrck        = r_lrck_sync[1];
  assign w_dat         = r_dat_sync[1];
  assign w_lrck_edge   = w_bclk_rise & (w_lrck != r_lrck_prev);
  assign w_left_start  = w_lrck_edge & ~w_lrck;
  assign w_right_start = w_lrck_edge & w_lrck;
  assign w_last_bit    = w_bclk_rise & (r_bit_cnt == CNT_W'(SAMPLE_BITS - 1));
  assign w_half_end    = (r_state == S_WRITE_HI) && (r_ptr == '1);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would make the synchroniser collapse to one stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bclk_sync <= '0;
      r_lrck_sync <= '0;
      r_dat_sync  <= '0;
    end else begin
      r_bclk_sync <= {r_bclk_sync[1:0], codec_bclk_i};
      r_lrck_sync <= {r_lrck_sync[0], codec_adclrck_i};
      r_dat_sync  <= {r_dat_sync[0], codec_adcdat_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: w_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (capture_en_i) w_next = S_WAIT_FRAME;
      S_WAIT_FRAME: begin
        if (!capture_en_i)     w_next = S_IDLE;
        else if (w_left_start) w_next = S_SKIP;
      end
      S_SKIP:       if (w_bclk_rise) w_next = S_SHIFT;
      S_SHIFT:      if (w_last_bit) w_next = (MONO && r_right) ? S_CH_END : S_WRITE_LO;
      S_WRITE_LO:   w_next = S_WRITE_HI;
      S_WRITE_HI:   w_next = S_CH_END;
      S_CH_END: begin
        if (!r_right) begin
          if (w_right_start) w_next = S_SKIP;
        end else if (!capture_en_i) begin
          w_next = S_IDLE;
        end else if (w_left_start) begin
          w_next = S_SKIP;
        end
      end
      default:      w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lrck_prev <= 1'b0;
      r_right     <= 1'b0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_ptr       <= '0;
      r_sel       <= 1'b0;
      r_filled    <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_bclk_rise) r_lrck_prev <= w_lrck;
      if (w_lrck_edge) r_right     <= w_lrck;

      if (r_state != S_SHIFT) r_bit_cnt <= '0;
      else if (w_bclk_rise)   r_bit_cnt <= r_bit_cnt + 1'b1;

      if (r_state == S_SHIFT && w_bclk_rise)
        r_shift <= {r_shift[SAMPLE_BITS-2:0], w_dat};

      if (r_state == S_WRITE_LO || r_state == S_WRITE_HI) r_ptr <= r_ptr + 1'b1;

      // An ack arriving with the boundary frees the other half, so it is a normal switch.
      if (w_half_end) begin
        r_filled <= 1'b1;
        if (r_filled && !capture_buffer_filled_ack_i) r_overrun <= 1'b1;
        else                                          r_sel     <= ~r_sel;
      end else if (capture_buffer_filled_ack_i) begin
        r_filled <= 1'b0;
      end
    end
  end

  always_comb begin
    capture_buffer_wren_o = 1'b0;
    capture_buffer_data_o = '0;
    case (r_state)
      S_WRITE_LO: begin
        capture_buffer_wren_o = 1'b1;
        capture_buffer_data_o = r_shift[7:0];
      end
      S_WRITE_HI: begin
        capture_buffer_wren_o = 1'b1;
        capture_buffer_data_o = r_shift[15:8];
      end
      default: ;
    endcase
  end

  assign capture_buffer_addr_o   = r_ptr;
  assign capture_buffer_sel_o    = r_sel;
  assign capture_buffer_filled_o = r_filled;
  assign capture_overrun_o       = r_overrun;

endmodule

// File: tb/tb_codec_adc_capture.sv
// Bench for codec_adc_capture: a behavioural I2S codec feeds logged random samples and a
// byte-stream scoreboard predicts every buffer write, half switch, handover and overrun.
module tb_codec_adc_capture;

  localparam int AB    = 6;
  localparam int HALF  = 1 << AB;
  localparam int SLOT  = 24;
  localparam int FRAME_CLK = 2 * SLOT * 8;
`ifdef CAPTURE_MONO_EN
  localparam int BPF = 2;
`else
  localparam int BPF = 4;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en, ack;
  logic          codec_bclk, codec_lrck, codec_dat;
  logic [AB-1:0] addr;
  logic          sel, wren, filled, overrun;
  logic [7:0]    data;

  codec_adc_capture #(.BUFFER_ADDR_BITS(AB), .SAMPLE_BITS(16)) dut (
    .clk                         (clk),
    .rst_n                       (rst_n),
    .capture_en_i                (en),
    .codec_bclk_i                (codec_bclk),
    .codec_adclrck_i             (codec_lrck),
    .codec_adcdat_i              (codec_dat),
    .capture_buffer_addr_o       (addr),
    .capture_buffer_sel_o        (sel),
    .capture_buffer_data_o       (data),
    .capture_buffer_wren_o       (wren),
    .capture_buffer_filled_o     (filled),
    .capture_buffer_filled_ack_i (ack),
    .capture_overrun_o           (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Codec model: every frame's samples are logged; bits 2..17 of each slot carry the sample.
  logic [15:0] log_l[$], log_r[$];
  bit          fixed_mode = 1'b1;

  initial begin
    logic [15:0] fl, fr, s;
    codec_bclk = 1'b0;
    codec_lrck = 1'b1;
    codec_dat  = 1'b0;
    #3;
    forever begin
      fl = fixed_mode ? 16'h1234 : 16'($urandom);
      fr = fixed_mode ? 16'hABCD : 16'($urandom);
      log_l.push_back(fl);
      log_r.push_back(fr);
      for (int ch = 0; ch < 2; ch++) begin
        for (int k = 0; k < SLOT; k++) begin
          s          = (ch == 1) ? fr : fl;
          codec_lrck = (ch == 1);
          codec_dat  = (k >= 2 && k <= 17) ? s[4'(17 - k)] : 1'($urandom);
          #40 codec_bclk = 1'b1;
          #40 codec_bclk = 1'b0;
        end
      end
    end
  end

  // Scoreboard state: which logged frame/byte is next, and the buffer bookkeeping.
  bit cap_active = 1'b0;
  int cap_frame  = 0;
  int cap_last   = 32'h7fff_ffff;
  int cap_byte   = 0;
  int m_ptr      = 0;
  bit m_sel      = 1'b0;
  bit m_filled   = 1'b0;
  bit m_overrun  = 1'b0;
  int n_bound    = 0;
  bit post_chk   = 1'b0;

  always @(negedge clk) begin
    logic [15:0] s;
    logic [7:0]  eb;
    if (post_chk) begin
      post_chk = 1'b0;
      check("switch_filled",  filled,  m_filled);
      check("switch_sel",     sel,     m_sel);
      check("switch_overrun", overrun, m_overrun);
      check("switch_addr",    addr,    0);
    end
    if (wren) begin
      if (!cap_active || cap_frame > cap_last || cap_frame >= log_l.size()) begin
        check("unexpected_wren", wren, 0);
      end else begin
        s  = (cap_byte < 2) ? log_l[cap_frame] : log_r[cap_frame];
        eb = cap_byte[0] ? s[15:8] : s[7:0];
        check("wr_addr", addr, m_ptr);
        check("wr_sel",  sel,  m_sel);
        check("wr_data", data, eb);
        m_ptr++;
        cap_byte++;
        if (cap_byte == BPF) begin
          cap_byte = 0;
          cap_frame++;
        end
        if (m_ptr == HALF) begin
          m_ptr = 0;
          if (m_filled) m_overrun = 1'b1;
          else begin
            m_sel    = ~m_sel;
            m_filled = 1'b1;
          end
          n_bound++;
          post_chk = 1'b1;
        end
      end
    end
  end

  task automatic wait_boundary(input int n);
    int b = 0;
    while (n_bound < n && b < 3 * (HALF / BPF) * FRAME_CLK) begin
      @(negedge clk);
      b++;
    end
    check("boundary_reached", (n_bound >= n), 1);
  endtask

  task automatic do_ack();
    @(negedge clk) ack = 1'b1;
    @(negedge clk) ack = 1'b0;
    m_filled = 1'b0;
    check("ack_clears_filled", filled, m_filled);
  endtask

  initial begin
    int lat;
    int start;
    rst_n = 1'b0;
    en    = 1'b0;
    ack   = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_outputs", {addr, sel, data, wren, filled, overrun}, 0);
    rst_n = 1'b1;

    // Start mid-right slot; capture begins with the next left frame.
    @(posedge codec_lrck);
    en         = 1'b1;
    cap_frame  = log_l.size();
    cap_active = 1'b1;
    @(negedge codec_lrck);
    lat = 0;
    while (!wren && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    check("first_write_latency", (lat >= 17 * 8 && lat <= 3 + 18 * 8), 1);
    repeat (2) @(negedge codec_lrck);
    fixed_mode = 1'b0;

    // First half fills and is handed over; a spurious second ack is ignored.
    wait_boundary(1);
    @(posedge codec_lrck);
    repeat (16) @(negedge clk);
    do_ack();
    repeat (8) @(negedge clk);
    do_ack();

    // No ack across the next two boundaries: second one overruns.
    wait_boundary(2);
    wait_boundary(3);
    @(negedge codec_lrck);
    check("overrun_sticky", overrun, 1);
    check("filled_held",    filled,  1);

    // Drop enable mid-left: that frame completes, nothing more is written.
    repeat (80) @(negedge clk);
    en       = 1'b0;
    cap_last = log_l.size() - 1;
    repeat (3) @(negedge codec_lrck);
    check("stop_after_frame", cap_frame, cap_last + 1);

    // Re-enable mid-right: resumes at the next left frame with the retained pointer.
    @(posedge codec_lrck);
    repeat (40) @(negedge clk);
    en        = 1'b1;
    cap_frame = log_l.size();
    cap_last  = 32'h7fff_ffff;
    start     = cap_frame;
    repeat (3) @(negedge codec_lrck);
    check("resume_frames", cap_frame, start + 2);

    // Asynchronous reset mid-shift with a pending handover.
    @(negedge codec_lrck);
    repeat (80) @(negedge clk);
    check("filled_before_reset", filled, m_filled);
    #2 rst_n = 1'b0;
    #1 check("reset_immediate", {addr, sel, data, wren, filled, overrun}, 0);
    cap_active = 1'b0;
    m_ptr = 0; m_sel = 1'b0; m_filled = 1'b0; m_overrun = 1'b0;
    cap_byte = 0; post_chk = 1'b0;
    repeat (20) @(negedge clk);
    cap_frame  = log_l.size();
    start      = cap_frame;
    cap_active = 1'b1;
    #2 rst_n = 1'b1;
    repeat (3) @(negedge codec_lrck);
    check("post_reset_frames", cap_frame, start + 2);
    check("post_reset_sel",    sel,       0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
